// File: rtl/mw_eeprom_writer.sv
// Microwire (93Cxx) command transmitter: serialises WRITE/ERASE/EWEN/EWDS frames, then polls DO for ready.
// Optional build macro MW_DO_SYNC_EN inserts a 2-flop synchroniser on mw_do ahead of ready sampling.
module mw_eeprom_writer #(
  parameter int unsigned ADDR_BITS   = 6,
  parameter int unsigned DATA_BITS   = 16,
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_req,
  input  logic [1:0]           cmd_op,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic [DATA_BITS-1:0] cmd_data,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 mw_cs,
  output logic                 mw_sk,
  output logic                 mw_di,
  input  logic                 mw_do
);

  localparam int unsigned FRAME_MAX = 3 + ADDR_BITS + DATA_BITS;
  localparam int unsigned BIT_W     = $clog2(FRAME_MAX + 1);
  localparam int unsigned TO_W      = $clog2(TIMEOUT_CYC + 1);

  localparam logic [7:0]       DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] LEN_LONG  = BIT_W'(FRAME_MAX);
  localparam logic [BIT_W-1:0] LEN_SHORT = BIT_W'(3 + ADDR_BITS);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_SHIFT, ST_DESEL, ST_POLL, ST_FIN
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           div_q, div_d;
  logic                 ph_q, ph_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [TO_W-1:0]      to_q, to_d;
  logic [FRAME_MAX-1:0] sr_q, sr_d;
  logic                 poll_q, poll_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic                 cs_q, cs_d;
  logic                 sk_q, sk_d;
  logic                 di_q, di_d;

  logic                 do_s;
  logic [7:0]           div_inc;
  logic [1:0]           frame_op;
  logic [ADDR_BITS-1:0] addr_field;
  logic [DATA_BITS-1:0] data_field;
  logic [FRAME_MAX-1:0] frame;

`ifdef MW_DO_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[0], mw_do};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  always_comb do_s = sync_q[1];
`else
  always_comb do_s = mw_do;
`endif

  // Host op codes are not the wire opcodes: EWEN/EWDS both travel as opcode 00,
  // distinguished by the top address bits (11 vs 00).
  always_comb begin
    frame_op   = cmd_op[0] ? cmd_op : 2'b00;
    addr_field = '0;
    data_field = '0;
    case (cmd_op)
      2'b01: begin
        addr_field = cmd_addr;
        data_field = cmd_data;
      end
      2'b11:   addr_field = cmd_addr;
      2'b10:   addr_field[ADDR_BITS-1 -: 2] = 2'b11;
      default: ;
    endcase
    frame = {1'b1, frame_op, addr_field, data_field};
  end

  always_comb div_inc = (div_q == 8'hFF) ? div_q : div_q + 8'd1;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    to_d    = to_q;
    sr_d    = sr_q;
    poll_d  = poll_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = error_q;
    cs_d    = cs_q;
    sk_d    = sk_q;
    di_d    = di_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_req) begin
          state_d = ST_SETUP;
          busy_d  = 1'b1;
          cs_d    = 1'b1;
          error_d = 1'b0;
          div_d   = '0;
          ph_d    = 1'b0;
          sr_d    = frame;
          bit_d   = (cmd_op == 2'b01) ? LEN_LONG : LEN_SHORT;
          poll_d  = cmd_op[0];
        end
      end
      ST_SETUP: begin
        if (div_q == DIV_LAST) begin
          state_d = ST_SHIFT;
          div_d   = '0;
          ph_d    = 1'b0;
          di_d    = sr_q[FRAME_MAX-1];
          sr_d    = sr_q << 1;
        end else begin
          div_d = div_inc;
        end
      end
      ST_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!ph_q) begin
            ph_d = 1'b1;
            sk_d = 1'b1;
          end else begin
            ph_d  = 1'b0;
            sk_d  = 1'b0;
            bit_d = (bit_q != '0) ? bit_q - BIT_W'(1) : bit_q;
            if (bit_q <= BIT_W'(1)) begin
              state_d = ST_DESEL;
              cs_d    = 1'b0;
              di_d    = 1'b0;
            end else begin
              di_d = sr_q[FRAME_MAX-1];
              sr_d = sr_q << 1;
            end
          end
        end else begin
          div_d = div_inc;
        end
      end
      ST_DESEL: begin
        // Two half-periods so the 8-bit divider never has to reach 2*CLK_DIV.
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!ph_q) begin
            ph_d = 1'b1;
          end else begin
            ph_d = 1'b0;
            if (poll_q) begin
              state_d = ST_POLL;
              cs_d    = 1'b1;
              to_d    = '0;
            end else begin
              state_d = ST_FIN;
              done_d  = 1'b1;
            end
          end
        end else begin
          div_d = div_inc;
        end
      end
      ST_POLL: begin
        to_d = (to_q == TO_MAX) ? to_q : to_q + TO_W'(1);
        if (do_s) begin
          state_d = ST_FIN;
          cs_d    = 1'b0;
          done_d  = 1'b1;
        end else if (to_q >= TO_LAST) begin
          state_d = ST_FIN;
          cs_d    = 1'b0;
          done_d  = 1'b1;
          error_d = 1'b1;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      ph_q    <= 1'b0;
      bit_q   <= '0;
      to_q    <= '0;
      sr_q    <= '0;
      poll_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      cs_q    <= 1'b0;
      sk_q    <= 1'b0;
      di_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      to_q    <= to_d;
      sr_q    <= sr_d;
      poll_q  <= poll_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      cs_q    <= cs_d;
      sk_q    <= sk_d;
      di_q    <= di_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign error = error_q;
  assign mw_cs = cs_q;
  assign mw_sk = sk_q;
  assign mw_di = di_q;

endmodule

// File: tb/tb_mw_eeprom_writer.sv
// Self-checking bench for mw_eeprom_writer: randomized commands checked against a frame/timing reference model.
module tb_mw_eeprom_writer;

  localparam int unsigned A  = 6;
  localparam int unsigned D  = 16;
  localparam int unsigned CD = 2;
  localparam int unsigned TO = 1000;
`ifdef MW_DO_SYNC_EN
  localparam int SYNC_LAT = 3;
`else
  localparam int SYNC_LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_req = 1'b0;
  logic [1:0]   cmd_op = '0;
  logic [A-1:0] cmd_addr = '0;
  logic [D-1:0] cmd_data = '0;
  logic         mw_do = 1'b0;
  logic         busy, done, error, mw_cs, mw_sk, mw_di;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mw_eeprom_writer #(
    .ADDR_BITS(A), .DATA_BITS(D), .CLK_DIV(CD), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_req(cmd_req), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .busy(busy), .done(done),
    .error(error), .mw_cs(mw_cs), .mw_sk(mw_sk), .mw_di(mw_di), .mw_do(mw_do)
  );

  // Bus monitor on the falling edge: captures DI at each SK rise and counts events.
  logic bits_q[$];
  int   done_cnt = 0, busy_cnt = 0, cs_bad = 0, di_bad = 0;
  logic prev_sk = 1'b0, prev_di = 1'b0;

  always @(negedge clk) begin
    if (mw_sk === 1'b1 && prev_sk === 1'b0) begin
      bits_q.push_back(mw_di);
      if (mw_cs !== 1'b1) cs_bad++;
    end
    if (mw_sk === 1'b1 && prev_sk === 1'b1 && mw_di !== prev_di) di_bad++;
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1) busy_cnt++;
    prev_sk = mw_sk;
    prev_di = mw_di;
  end

  // Reference frame: start bit, wire opcode, address field, optional data, as an integer.
  function automatic void model_frame(input logic [1:0] op, input logic [A-1:0] addr,
                                      input logic [D-1:0] data, output int len,
                                      output longint unsigned val);
    longint unsigned code, af;
    if (op == 2'b01)      code = 1;
    else if (op == 2'b11) code = 3;
    else                  code = 0;
    if (op == 2'b01 || op == 2'b11) af = 64'(addr);
    else if (op == 2'b10)           af = 3 * (64'd1 << (A - 2));
    else                            af = 0;
    val = (64'd1 << (A + 2)) + code * (64'd1 << A) + af;
    len = 3 + A;
    if (op == 2'b01) begin
      val = val * (64'd1 << D) + 64'(data);
      len = len + D;
    end
  endfunction

  function automatic longint unsigned got_frame(input int start, input int len);
    longint unsigned acc = 0;
    for (int i = 0; i < len; i++)
      acc = acc * 2 + ((start + i < bits_q.size() && bits_q[start + i] === 1'b1) ? 1 : 0);
    return acc;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [1:0] op, input logic [A-1:0] addr, input logic [D-1:0] data);
    cmd_req  = 1'b1;
    cmd_op   = op;
    cmd_addr = addr;
    cmd_data = data;
    tick();
    cmd_req = 1'b0;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [A-1:0] addr, input logic [D-1:0] data,
                         input int delay, input bit early, input string tag);
    int b0, bz0, d0, e0, len, k, low, lat, pc, exp_busy;
    longint unsigned val, got;
    bit prog;
    b0 = bits_q.size(); bz0 = busy_cnt; d0 = done_cnt; e0 = cs_bad + di_bad;
    model_frame(op, addr, data, len, val);
    prog = (op == 2'b01) || (op == 2'b11);
    send(op, addr, data);
    n_checks++;
    if (busy !== 1'b1 || error !== 1'b0) begin
      n_fail++; $display("FAIL %s accept: busy=%b error=%b, expected busy=1 error=0", tag, busy, error);
    end
    k = 0;
    while (mw_cs !== 1'b0 && k < 4000) begin tick(); k++; end
    n_checks++;
    if (k >= 4000) begin n_fail++; $display("FAIL %s frame_end: cs still high after %0d cycles", tag, k); end
    if (early) mw_do = 1'b1;
    low = 0;
    while (mw_cs === 1'b0 && done !== 1'b1 && low < 100) begin tick(); low++; end
    n_checks++;
    if (low != 2 * CD) begin n_fail++; $display("FAIL %s desel_len: got %0d expected %0d", tag, low, 2 * CD); end
    pc = 0;
    if (prog) begin
      if (!early) begin
        repeat (delay) tick();
        mw_do = 1'b1;
      end
      lat = 0;
      while (done !== 1'b1 && lat < 2000) begin tick(); lat++; end
      n_checks++;
      if (lat != (early ? 1 : SYNC_LAT)) begin
        n_fail++; $display("FAIL %s ready_lat: got %0d expected %0d", tag, lat, early ? 1 : SYNC_LAT);
      end
      pc = early ? 1 : delay + SYNC_LAT;
    end
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL %s done: got %b expected 1", tag, done); end
    n_checks++;
    if ({busy, error} !== 2'b10) begin
      n_fail++; $display("FAIL %s fin_flags: busy,error=%b expected 10", tag, {busy, error});
    end
    mw_do = 1'b0;
    tick();
    n_checks++;
    if ({done, busy} !== 2'b00) begin
      n_fail++; $display("FAIL %s idle: done,busy=%b expected 00", tag, {done, busy});
    end
    got = got_frame(b0, len);
    n_checks++;
    if (bits_q.size() - b0 != len) begin
      n_fail++; $display("FAIL %s nbits: got %0d expected %0d", tag, bits_q.size() - b0, len);
    end
    n_checks++;
    if (got != val) begin n_fail++; $display("FAIL %s frame: got %0h expected %0h", tag, got, val); end
    n_checks++;
    if (cs_bad + di_bad - e0 != 0) begin
      n_fail++; $display("FAIL %s sk_timing: %0d violations expected 0", tag, cs_bad + di_bad - e0);
    end
    n_checks++;
    if (done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL %s done_pulses: got %0d expected 1", tag, done_cnt - d0);
    end
    exp_busy = CD + 2 * CD * len + 2 * CD + pc + 1;
    n_checks++;
    if (busy_cnt - bz0 != exp_busy) begin
      n_fail++; $display("FAIL %s busy_cycles: got %0d expected %0d", tag, busy_cnt - bz0, exp_busy);
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({busy, done, error, mw_cs, mw_sk, mw_di} !== 6'b0) begin
      n_fail++; $display("FAIL reset_vals: got %b expected 000000", {busy, done, error, mw_cs, mw_sk, mw_di});
    end
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({busy, done, error, mw_cs, mw_sk, mw_di} !== 6'b0) begin
      n_fail++; $display("FAIL post_reset_idle: got %b expected 000000", {busy, done, error, mw_cs, mw_sk, mw_di});
    end
  endtask

  task automatic test_ewen();
    run_cmd(2'b10, A'($urandom), D'($urandom), 0, 1'b0, "ewen");
  endtask

  task automatic test_write();
    run_cmd(2'b01, 6'h2A, 16'hBEEF, 50, 1'b0, "write_beef");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      run_cmd(2'($urandom), A'($urandom), D'($urandom), int'($urandom_range(0, 40)),
              1'($urandom), "random");
  endtask

  task automatic test_timeout();
    int k, t, d0;
    d0 = done_cnt;
    mw_do = 1'b0;
    send(2'b11, A'($urandom), D'(0));
    k = 0;
    while (mw_cs !== 1'b0 && k < 4000) begin tick(); k++; end
    while (mw_cs === 1'b0 && k < 4000) begin tick(); k++; end
    n_checks++;
    if (k >= 4000) begin n_fail++; $display("FAIL timeout poll_entry: no POLL within %0d cycles", k); end
    t = 0;
    while (done !== 1'b1 && t < int'(TO) + 100) begin tick(); t++; end
    n_checks++;
    if (t != int'(TO)) begin n_fail++; $display("FAIL timeout poll_cycles: got %0d expected %0d", t, TO); end
    n_checks++;
    if (error !== 1'b1) begin n_fail++; $display("FAIL timeout error_set: got %b expected 1", error); end
    repeat (4) tick();
    n_checks++;
    if ({error, busy, done} !== 3'b100) begin
      n_fail++; $display("FAIL timeout sticky: error,busy,done=%b expected 100", {error, busy, done});
    end
    n_checks++;
    if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL timeout done_pulses: got %0d expected 1", done_cnt - d0); end
    run_cmd(2'b00, A'($urandom), D'($urandom), 0, 1'b0, "error_clear");
  endtask

  task automatic test_ignore();
    int b0, d0, len, i;
    longint unsigned val;
    logic [A-1:0] addr;
    logic [D-1:0] data;
    addr = A'($urandom); data = D'($urandom);
    b0 = bits_q.size(); d0 = done_cnt;
    model_frame(2'b01, addr, data, len, val);
    mw_do = 1'b1;
    send(2'b01, addr, data);
    i = 0;
    while (done !== 1'b1 && i < 2000) begin
      cmd_req  = (i % 3 == 0) && (busy === 1'b1);
      cmd_op   = 2'($urandom);
      cmd_addr = A'($urandom);
      cmd_data = D'($urandom);
      tick();
      i++;
    end
    cmd_req = 1'b0;
    mw_do = 1'b0;
    repeat (10) tick();
    n_checks++;
    if (got_frame(b0, len) != val || bits_q.size() - b0 != len) begin
      n_fail++; $display("FAIL ignore frame: got %0h (%0d bits) expected %0h (%0d bits)",
                         got_frame(b0, len), bits_q.size() - b0, val, len);
    end
    n_checks++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL ignore done_pulses: got %0d busy=%b expected 1 busy=0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_reset_mid();
    int b0, d0, k;
    b0 = bits_q.size(); d0 = done_cnt;
    send(2'b01, A'($urandom), D'($urandom));
    k = 0;
    while (bits_q.size() - b0 < 6 && k < 500) begin tick(); k++; end
    n_checks++;
    if (mw_cs !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid in_shift: cs=%b busy=%b expected 1 1", mw_cs, busy);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({mw_cs, mw_sk, mw_di, busy, done} !== 5'b0) begin
      n_fail++; $display("FAIL rst_mid async: cs,sk,di,busy,done=%b expected 00000", {mw_cs, mw_sk, mw_di, busy, done});
    end
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (done_cnt - d0 != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid no_done: pulses=%0d busy=%b expected 0 0", done_cnt - d0, busy);
    end
    run_cmd(2'b00, A'($urandom), D'($urandom), 0, 1'b0, "post_rst_ewds");
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_cnt;
    run_cmd(2'b01, A'($urandom), D'($urandom), int'($urandom_range(0, 10)), 1'b0, "b2b_write");
    run_cmd(2'b00, A'($urandom), D'($urandom), 0, 1'b0, "b2b_ewds");
    n_checks++;
    if (done_cnt - d0 != 2) begin n_fail++; $display("FAIL b2b done_pulses: got %0d expected 2", done_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_ewen();
    test_write();
    test_random();
    test_timeout();
    test_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
